traffic_conflict_monitor: RTL and testbench

//   Safety stage directly downstream of the traffic light controller. Consumes its four lamp

---
 rtl/traffic_conflict_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic light controller and the physical lamps: passes clean
// aspects through one register stage, and latches a flashing all-red fault on conflicts,
// invalid aspects or a stalled controller.
module traffic_conflict_monitor #(
    parameter int FILTER_CYC  = 2,
    parameter int WDOG_CYC    = 120,
    parameter int FLASH_HALF  = 1,
    parameter int STARTUP_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int FILT_W  = $clog2(FILTER_CYC + 1);
    localparam int WDOG_W  = $clog2(WDOG_CYC + 1);
    localparam int FLASH_W = $clog2(FLASH_HALF + 1);
    localparam int START_W = $clog2(STARTUP_CYC + 1);

    localparam logic [11:0] ALL_RED  = 12'b100_100_100_100;
    localparam logic [11:0] ALL_DARK = 12'b000_000_000_000;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_CONFLICT = 2'b01;
    localparam logic [1:0] CODE_INVALID  = 2'b10;
    localparam logic [1:0] CODE_WDOG     = 2'b11;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [11:0]         lamps_q, lamps_d;
    logic [11:0]         prev_q;
    logic                fault_q, fault_d;
    logic [1:0]          code_q, code_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic [START_W-1:0]  start_q, start_d;
    logic [FLASH_W-1:0]  flash_cnt_q, flash_cnt_d;
    logic                flash_dark_q, flash_dark_d;

    logic [11:0]         lights;
    logic [2:0]          lane [4];
    logic [3:0]          lane_invalid;
    logic                invalid;
    logic                conflict;
    logic                bad;
    logic                changed;
    logic [FILT_W-1:0]   filt_inc;
    logic [WDOG_W-1:0]   wdog_inc;

    assign lights  = {light_M1, light_M2, light_MT, light_S};
    assign lane[0] = light_M1;
    assign lane[1] = light_M2;
    assign lane[2] = light_MT;
    assign lane[3] = light_S;

    // An aspect is valid only when exactly one of red/yellow/green is lit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_invalid[gi] = !((lane[gi] == 3'b001) ||
                                        (lane[gi] == 3'b010) ||
                                        (lane[gi] == 3'b100));
        end
    endgenerate

    assign invalid  = |lane_invalid;
    assign conflict = (light_S[0] & (light_M1[0] | light_M2[0] | light_MT[0])) |
                      (light_MT[0] & light_M2[0]);
    assign bad      = invalid | conflict;
    assign changed  = (lights != prev_q);

    assign filt_inc = (filt_q >= FILT_W'(FILTER_CYC)) ? filt_q : filt_q + 1'b1;
    assign wdog_inc = (wdog_q >= WDOG_W'(WDOG_CYC)) ? wdog_q : wdog_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_STARTUP;
            lamps_q      <= ALL_RED;
            prev_q       <= '0;
            fault_q      <= 1'b0;
            code_q       <= CODE_NONE;
            filt_q       <= '0;
            wdog_q       <= '0;
            start_q      <= '0;
            flash_cnt_q  <= '0;
            flash_dark_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lamps_q      <= lamps_d;
            prev_q       <= lights;
            fault_q      <= fault_d;
            code_q       <= code_d;
            filt_q       <= filt_d;
            wdog_q       <= wdog_d;
            start_q      <= start_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_dark_q <= flash_dark_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lamps_d      = lamps_q;
        fault_d      = fault_q;
        code_d       = code_q;
        filt_d       = filt_q;
        wdog_d       = wdog_q;
        start_d      = start_q;
        flash_cnt_d  = flash_cnt_q;
        flash_dark_d = flash_dark_q;

        case (state_q)
            ST_STARTUP: begin
                lamps_d = ALL_RED;
                filt_d  = '0;
                wdog_d  = '0;
                if (start_q >= START_W'(STARTUP_CYC - 1)) begin
                    state_d = ST_MONITOR;
                    start_d = '0;
                end else begin
                    start_d = start_q + 1'b1;
                end
            end

            ST_MONITOR: begin
                wdog_d = changed ? '0 : wdog_inc;
                if (bad) begin
                    lamps_d = ALL_RED;
                    filt_d  = filt_inc;
                end else begin
                    lamps_d = lights;
                    filt_d  = '0;
                end

                // Filter is checked first so its code wins a same-edge tie with the watchdog.
                if (bad && (filt_inc >= FILT_W'(FILTER_CYC))) begin
                    state_d = ST_FAULT;
                    code_d  = conflict ? CODE_CONFLICT : CODE_INVALID;
                end else if (!changed && (wdog_inc >= WDOG_W'(WDOG_CYC))) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_WDOG;
                end

                if (state_d == ST_FAULT) begin
                    fault_d      = 1'b1;
                    lamps_d      = ALL_RED;
                    filt_d       = '0;
                    wdog_d       = '0;
                    flash_cnt_d  = '0;
                    flash_dark_d = 1'b0;
                end
            end

            ST_FAULT: begin
                if (fault_clr && !bad) begin
                    state_d      = ST_STARTUP;
                    fault_d      = 1'b0;
                    code_d       = CODE_NONE;
                    lamps_d      = ALL_RED;
                    filt_d       = '0;
                    wdog_d       = '0;
                    start_d      = '0;
                    flash_cnt_d  = '0;
                    flash_dark_d = 1'b0;
                end else begin
                    if (flash_cnt_q >= FLASH_W'(FLASH_HALF - 1)) begin
                        flash_cnt_d  = '0;
                        flash_dark_d = !flash_dark_q;
                    end else begin
                        flash_cnt_d  = flash_cnt_q + 1'b1;
                    end
                    lamps_d = flash_dark_d ? ALL_DARK : ALL_RED;
                end
            end

            default: begin
                state_d = ST_STARTUP;
                lamps_d = ALL_RED;
                fault_d = 1'b0;
                code_d  = CODE_NONE;
            end
        endcase
    end

    assign lamp_M1    = lamps_q[11:9];
    assign lamp_M2    = lamps_q[8:6];
    assign lamp_MT    = lamps_q[5:3];
    assign lamp_S     = lamps_q[2:0];
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: startup hold, glitch filtering, conflict,
// invalid and watchdog faults, fault clearing and asynchronous reset.
module tb_traffic_conflict_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       fault_clr;
    logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
    logic       fault;
    logic [1:0] fault_code;
    logic [11:0] lamps_w;

    int checks   = 0;
    int failures = 0;

    localparam logic [11:0] RED   = 12'b100_100_100_100;
    localparam logic [11:0] DARK  = 12'b000_000_000_000;
    localparam logic [11:0] CLN_A = 12'b001_001_100_100;
    localparam logic [11:0] CLN_B = 12'b010_010_100_100;
    localparam logic [11:0] CLN_T = 12'b001_100_001_100;
    localparam logic [11:0] CLN_R = 12'b001_100_100_100;
    localparam logic [11:0] CF_S1 = 12'b001_001_100_001;
    localparam logic [11:0] CF_ST = 12'b100_100_001_001;
    localparam logic [11:0] INV_2 = 12'b001_011_100_100;
    localparam logic [11:0] BOTH  = 12'b011_100_100_001;

    traffic_conflict_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (light_M1),
        .light_M2   (light_M2),
        .light_MT   (light_MT),
        .light_S    (light_S),
        .fault_clr  (fault_clr),
        .lamp_M1    (lamp_M1),
        .lamp_M2    (lamp_M2),
        .lamp_MT    (lamp_MT),
        .lamp_S     (lamp_S),
        .fault      (fault),
        .fault_code (fault_code)
    );

    assign lamps_w = {lamp_M1, lamp_M2, lamp_MT, lamp_S};

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] v);
        {light_M1, light_M2, light_MT, light_S} = v;
    endtask

    // Clears a fault with clean inputs and walks through the startup hold into pass-through.
    task automatic recover;
        drive(CLN_A);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00 || lamps_w !== RED) begin
            failures++;
            $display("FAIL recover_clear fault=%b code=%b lamps=%b exp 0/00/%b", fault, fault_code, lamps_w, RED);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (lamps_w !== RED) begin
                failures++;
                $display("FAIL recover_hold%0d lamps=%b exp %b", i, lamps_w, RED);
            end
        end
        tick();
        checks++;
        if (lamps_w !== CLN_A || fault !== 1'b0) begin
            failures++;
            $display("FAIL recover_pass lamps=%b fault=%b exp %b/0", lamps_w, fault, CLN_A);
        end
    endtask

    task automatic test_reset;
        fault_clr = 1'b0;
        drive(CLN_A);
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        checks++;
        if (lamps_w !== RED || fault !== 1'b0 || fault_code !== 2'b00) begin
            failures++;
            $display("FAIL reset_values lamps=%b fault=%b code=%b exp %b/0/00", lamps_w, fault, fault_code, RED);
        end
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (lamps_w !== RED || fault !== 1'b0) begin
                failures++;
                $display("FAIL startup_hold%0d lamps=%b fault=%b exp %b/0", i, lamps_w, fault, RED);
            end
        end
        tick();
        checks++;
        if (lamps_w !== CLN_A) begin
            failures++;
            $display("FAIL startup_pass lamps=%b exp %b", lamps_w, CLN_A);
        end
        drive(CLN_B);
        #2;
        checks++;
        if (lamps_w !== CLN_A) begin
            failures++;
            $display("FAIL no_comb_path lamps=%b exp %b", lamps_w, CLN_A);
        end
        tick();
        checks++;
        if (lamps_w !== CLN_B) begin
            failures++;
            $display("FAIL pass_latency lamps=%b exp %b", lamps_w, CLN_B);
        end
    endtask

    task automatic test_glitch;
        drive(CF_S1);
        tick();
        checks++;
        if (lamps_w !== RED || fault !== 1'b0) begin
            failures++;
            $display("FAIL glitch_red lamps=%b fault=%b exp %b/0", lamps_w, fault, RED);
        end
        drive(CLN_A);
        tick();
        checks++;
        if (lamps_w !== CLN_A || fault !== 1'b0) begin
            failures++;
            $display("FAIL glitch_resume lamps=%b fault=%b exp %b/0", lamps_w, fault, CLN_A);
        end
        drive(CLN_T);
        tick();
        checks++;
        if (lamps_w !== CLN_T) begin
            failures++;
            $display("FAIL legal_m1_mt lamps=%b exp %b", lamps_w, CLN_T);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            drive(CF_S1);
            tick();
            checks++;
            if (lamps_w !== RED || fault !== 1'b0) begin
                failures++;
                $display("FAIL alt_bad%0d lamps=%b fault=%b exp %b/0", i, lamps_w, fault, RED);
            end
            drive(CLN_A);
            tick();
            checks++;
            if (lamps_w !== CLN_A || fault !== 1'b0) begin
                failures++;
                $display("FAIL alt_clean%0d lamps=%b fault=%b exp %b/0", i, lamps_w, fault, CLN_A);
            end
        end
    endtask

    task automatic test_conflict;
        drive(CF_ST);
        tick();
        checks++;
        if (fault !== 1'b0 || lamps_w !== RED) begin
            failures++;
            $display("FAIL conflict_first fault=%b lamps=%b exp 0/%b", fault, lamps_w, RED);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || lamps_w !== RED) begin
            failures++;
            $display("FAIL conflict_latch fault=%b code=%b lamps=%b exp 1/01/%b", fault, fault_code, lamps_w, RED);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (lamps_w !== ((i % 2 == 0) ? DARK : RED) || fault_code !== 2'b01) begin
                failures++;
                $display("FAIL flash%0d lamps=%b code=%b exp %b/01", i, lamps_w, fault_code, (i % 2 == 0) ? DARK : RED);
            end
        end
        recover();
    endtask

    task automatic test_invalid;
        drive(INV_2);
        tick();
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10) begin
            failures++;
            $display("FAIL invalid_latch fault=%b code=%b exp 1/10", fault, fault_code);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b10) begin
            failures++;
            $display("FAIL clr_on_bad fault=%b code=%b exp 1/10", fault, fault_code);
        end
        drive(CLN_R);
        tick();
        checks++;
        if (fault !== 1'b1) begin
            failures++;
            $display("FAIL hold_without_clr fault=%b exp 1", fault);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00 || lamps_w !== RED) begin
            failures++;
            $display("FAIL clr_clean fault=%b code=%b lamps=%b exp 0/00/%b", fault, fault_code, lamps_w, RED);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (lamps_w !== RED) begin
                failures++;
                $display("FAIL clr_hold%0d lamps=%b exp %b", i, lamps_w, RED);
            end
        end
        tick();
        checks++;
        if (lamps_w !== CLN_R) begin
            failures++;
            $display("FAIL clr_pass lamps=%b exp %b", lamps_w, CLN_R);
        end
    endtask

    task automatic test_priority;
        drive(BOTH);
        tick();
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b01) begin
            failures++;
            $display("FAIL conflict_wins fault=%b code=%b exp 1/01", fault, fault_code);
        end
        recover();
    endtask

    task automatic test_watchdog;
        drive(CLN_B);
        tick();
        repeat (118) tick();
        checks++;
        if (fault !== 1'b0 || lamps_w !== CLN_B) begin
            failures++;
            $display("FAIL wdog_118 fault=%b lamps=%b exp 0/%b", fault, lamps_w, CLN_B);
        end
        drive(CLN_A);
        tick();
        checks++;
        if (fault !== 1'b0) begin
            failures++;
            $display("FAIL wdog_change119 fault=%b exp 0", fault);
        end
        repeat (119) tick();
        checks++;
        if (fault !== 1'b0 || lamps_w !== CLN_A) begin
            failures++;
            $display("FAIL wdog_119 fault=%b lamps=%b exp 0/%b", fault, lamps_w, CLN_A);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b11 || lamps_w !== RED) begin
            failures++;
            $display("FAIL wdog_120 fault=%b code=%b lamps=%b exp 1/11/%b", fault, fault_code, lamps_w, RED);
        end
    endtask

    task automatic test_async_reset;
        checks++;
        if (fault !== 1'b1) begin
            failures++;
            $display("FAIL async_pre fault=%b exp 1", fault);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (lamps_w !== RED || fault !== 1'b0 || fault_code !== 2'b00) begin
            failures++;
            $display("FAIL async_reset lamps=%b fault=%b code=%b exp %b/0/00", lamps_w, fault, fault_code, RED);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (lamps_w !== RED || fault !== 1'b0) begin
            failures++;
            $display("FAIL post_reset lamps=%b fault=%b exp %b/0", lamps_w, fault, RED);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_back_to_back();
        test_conflict();
        test_invalid();
        test_priority();
        test_watchdog();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
